counter_arbiter: RTL and testbench
==================================

# counter_arbiter

Round-robin controller that shares one WIDTH-bit up-counter among NUM_REQ requesters. Each requester asks for a counting run to its own terminal value. The arbiter grants one requester at a time, runs the shared counter from 0 up to that requester's limit, and then signals completion. It sits between the client blocks and the shared counter datapath, and replaces per-client private counters.

## Interface
- NUM_REQ, default 4: number of requesters, ≥2.
- WIDTH, default 8: counter and limit width.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  level request, one bit per requester.
- limit  input  NUM_REQ*WIDTH  terminal count per requester; requester i uses bits [i*WIDTH +: WIDTH].
- grant  output  NUM_REQ  one-hot owner of the counter, all zeros when idle.
- busy  output  1  high while a run is active (state RUN).
- count  output  WIDTH  current shared counter value.
- done  output  1  one-cycle pulse when a run completes.
- done_id  output  clog2(NUM_REQ)  index of the requester whose run completed; valid with done.

## Operation
- All outputs are registered.
- Reset values: grant=0, busy=0, count=0, done=0, done_id=0, state=IDLE, priority pointer=0 (requester 0 has highest priority).
- The FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - If any req bit is high, pick the first set bit found by scanning upward from the pointer and wrapping modulo NUM_REQ.
  - Latch that requester's limit into lim.
  - Set grant to its one-hot value, busy=1, count=0.
  - Set pointer = winner+1 mod NUM_REQ and go to RUN.
  - If no req bit is high, stay in IDLE with all outputs at reset values.
- RUN, checked in priority order each cycle:
  - req[owner] low: abort. Go to IDLE, grant=0, busy=0, count=0, no done pulse.
  - Else count==lim: go to DONE, done=1, done_id=owner, grant=0, busy=0. count holds lim.
  - Else count = count+1.
- DONE:
  - Stay one cycle; done returns to 0 and count to 0.
  - Go to IDLE. req is not sampled in this state.
- Limit sampling: limit is sampled only at grant. Changes to limit during RUN are ignored.
- Counter range: count never exceeds lim, so no modulo wrap occurs. lim=2^WIDTH-1 is legal.
- lim=0: the run lasts one RUN cycle with count=0, then DONE.
- Requester protocol: drop req after seeing done. A req still high in IDLE is re-arbitrated, but the advanced pointer gives other requesters priority first.
- Simultaneous requests: resolved strictly by the pointer. No requester waits more than NUM_REQ-1 runs.
- Reset asserted mid-run: the next edge forces every register to its reset value, with no done pulse.

## Timing
- req seen in IDLE at cycle t → grant/busy high and count=0 at t+1.
- count=k at t+1+k; count=lim at t+1+lim.
- done=1 and grant=0 at t+2+lim.
- IDLE at t+3+lim; the earliest next grant is at t+4+lim.
- Abort: req[owner] low at cycle c in RUN → grant=0, busy=0, count=0 at c+1.
- Exactly one grant bit is high whenever busy=1. grant is all zeros otherwise.
- done is exactly one cycle wide. done and busy are never both high.

## Test plan
- Reset, then single requester: req[2]=1, limit2=5 from cycle 0.
  - grant=4'b0100 at cycle 1.
  - count goes 0..5 over cycles 1-6.
  - done=1 with done_id=2 at cycle 7; grant=0.
- Round-robin fairness: req=4'b1111 held, all limits=1.
  - Grants occur in the order 0,1,2,3,0.
  - Runs are spaced 4 cycles apart; done_id follows the same order.
- Zero limit: req[1]=1, limit1=0.
  - busy high for exactly 1 cycle with count=0.
  - done at grant+1.
- Abort: req[0]=1, limit0=10; drop req[0] when count=3.
  - Next cycle grant=0, busy=0, count=0.
  - No done pulse.
  - Pending req[3] is granted 2 cycles later.
- Max limit and limit change: limit=8'hFF.
  - count reaches 255 without wrapping, then done.
  - Changing limit mid-run to 2 does not shorten the run.
- Reset mid-run: assert reset at count=4.
  - All outputs 0 the next cycle.
  - Priority pointer returns to 0: with req=4'b1010 after reset, requester 1 is granted first.

Source files
------------

// File: rtl/counter_arbiter_if.sv
// Bundle of requester-side and counter-side signals for counter_arbiter.
// The master side (client blocks) drives req/limit. The slave side
// (the arbiter) returns grant, busy, count and the completion pulse.
interface counter_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] limit;
    logic [NUM_REQ-1:0]       grant;
    logic                     busy;
    logic [WIDTH-1:0]         count;
    logic                     done;
    logic [IDW-1:0]           done_id;

    modport master (
        output req, limit,
        input  grant, busy, count, done, done_id
    );

    modport slave (
        input  req, limit,
        output grant, busy, count, done, done_id
    );
endinterface

// File: rtl/counter_arbiter.sv
// Round-robin owner of one shared up-counter. The granted requester gets a
// run from 0 up to its own limit (sampled at grant), followed by a one-cycle
// done pulse. Dropping req during a run aborts it without a done pulse.
module counter_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    counter_arbiter_if.slave     bus,
    output logic [1:0]           state_dbg
);
    localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]         state_q,   state_d;
    logic [NUM_REQ-1:0] grant_q,   grant_d;
    logic               busy_q,    busy_d;
    logic [WIDTH-1:0]   count_q,   count_d;
    logic               done_q,    done_d;
    logic [IDW-1:0]     done_id_q, done_id_d;
    logic [IDW-1:0]     ptr_q,     ptr_d;
    logic [IDW-1:0]     owner_q,   owner_d;
    logic [WIDTH-1:0]   lim_q,     lim_d;

    // Winner of the round-robin scan, starting at the pointer and wrapping.
    logic               found;
    logic [IDW-1:0]     win;
    int                 scan_idx;

    // Scan upward from the pointer for the first active request.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        scan_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            scan_idx = int'(ptr_q) + i;
            if (scan_idx >= NUM_REQ) begin
                scan_idx = scan_idx - NUM_REQ;
            end
            if (!found && bus.req[scan_idx]) begin
                found = 1'b1;
                win   = IDW'(scan_idx);
            end
        end
    end

    // Next-state and output logic for IDLE -> RUN -> DONE.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        count_d   = count_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        lim_d     = lim_q;
        case (state_q)
            ST_IDLE: begin
                grant_d   = '0;
                busy_d    = 1'b0;
                count_d   = '0;
                done_id_d = '0;
                if (found) begin
                    owner_d  = win;
                    lim_d    = bus.limit[int'(win)*WIDTH +: WIDTH];
                    grant_d  = NUM_REQ'(1) << win;
                    busy_d   = 1'b1;
                    count_d  = '0;
                    ptr_d    = (win == IDW'(NUM_REQ-1)) ? '0 : win + IDW'(1);
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!bus.req[owner_q]) begin
                    // Owner withdrew: silent abort back to idle.
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (count_q == lim_q) begin
                    // Count is left at lim for the done cycle.
                    grant_d   = '0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    done_id_d = owner_q;
                    state_d   = ST_DONE;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            ST_DONE: begin
                // req is deliberately not looked at here.
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            ptr_q     <= '0;
            owner_q   <= '0;
            lim_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            lim_q     <= lim_d;
        end
    end

    assign bus.grant   = grant_q;
    assign bus.busy    = busy_q;
    assign bus.count   = count_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_counter_arbiter.sv
// Directed bench for counter_arbiter: single run, round-robin order,
// zero limit, abort, maximum limit with a mid-run limit change, and reset
// in the middle of a run.
module tb_counter_arbiter;
    localparam int NUM_REQ = 4;
    localparam int WIDTH   = 8;

    logic        clock;
    logic        reset;
    logic [3:0]  req_r;
    logic [31:0] limit_r;
    logic [1:0]  state_dbg;

    int n_checks;
    int n_fail;

    counter_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

    assign bus.req   = req_r;
    assign bus.limit = limit_r;

    counter_arbiter #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus.slave),
        .state_dbg (state_dbg)
    );

    // Clock generation
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one cycle; outputs are sampled and inputs driven 1ns after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_grant"}, 32'(bus.grant), 32'h0);
        check_eq({tag, "_busy"},  32'(bus.busy),  32'h0);
        check_eq({tag, "_count"}, 32'(bus.count), 32'h0);
        check_eq({tag, "_done"},  32'(bus.done),  32'h0);
    endtask

    task automatic check_run(input string tag, input logic [3:0] g, input int k);
        check_eq({tag, "_grant"}, 32'(bus.grant), 32'(g));
        check_eq({tag, "_busy"},  32'(bus.busy),  32'h1);
        check_eq({tag, "_count"}, 32'(bus.count), 32'(k));
        check_eq({tag, "_done"},  32'(bus.done),  32'h0);
    endtask

    task automatic check_done(input string tag, input int id, input int lim);
        check_eq({tag, "_done"},    32'(bus.done),    32'h1);
        check_eq({tag, "_done_id"}, 32'(bus.done_id), 32'(id));
        check_eq({tag, "_grant"},   32'(bus.grant),   32'h0);
        check_eq({tag, "_busy"},    32'(bus.busy),    32'h0);
        check_eq({tag, "_count"},   32'(bus.count),   32'(lim));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        req_r    = 4'b0000;
        limit_r  = 32'h0;
        tick();
        tick();
        check_idle("reset");
        check_eq("reset_done_id", 32'(bus.done_id), 32'h0);
        reset = 1'b0;

        // Single requester 2 with limit 5: grant at 1, count 0..5, done at 7.
        req_r   = 4'b0100;
        limit_r = {8'd0, 8'd5, 8'd0, 8'd0};
        check_idle("single_c0");
        for (int k = 0; k <= 5; k++) begin
            tick();
            check_run("single_run", 4'b0100, k);
        end
        tick();
        check_done("single_done", 2, 5);
        req_r = 4'b0000;
        tick();
        check_idle("single_after");
        tick();
        check_idle("single_idle");

        // Fairness: reset pointer, all four requesting with limit 1.
        reset = 1'b1;
        tick();
        reset   = 1'b0;
        req_r   = 4'b1111;
        limit_r = {8'd1, 8'd1, 8'd1, 8'd1};
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            for (int r = 0; r < 5; r++) begin
                tick();
                check_run("rr_grant", 4'(1 << order[r]), 0);
                tick();
                check_run("rr_count", 4'(1 << order[r]), 1);
                tick();
                check_done("rr_done", order[r], 1);
                tick();
                check_idle("rr_gap");
            end
        end
        req_r = 4'b0000;
        tick();
        check_idle("rr_quiet");

        // Zero limit on requester 1: one RUN cycle, done right after grant.
        req_r   = 4'b0010;
        limit_r = {8'd7, 8'd7, 8'd0, 8'd7};
        tick();
        check_run("zero_run", 4'b0010, 0);
        tick();
        check_done("zero_done", 1, 0);
        req_r = 4'b0000;
        tick();
        check_idle("zero_after");
        tick();
        check_idle("zero_idle");

        // Abort: requester 0 drops at count 3; pending requester 3 follows.
        req_r   = 4'b0001;
        limit_r = {8'd2, 8'd0, 8'd0, 8'd10};
        tick();
        check_run("abort_run", 4'b0001, 0);
        req_r = 4'b1001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check_run("abort_run", 4'b0001, k);
        end
        req_r = 4'b1000;
        tick();
        check_idle("abort_drop");
        tick();
        check_run("abort_next", 4'b1000, 0);
        tick();
        check_run("abort_next", 4'b1000, 1);
        tick();
        check_run("abort_next", 4'b1000, 2);
        tick();
        check_done("abort_next_done", 3, 2);
        req_r = 4'b0000;
        tick();
        tick();
        check_idle("abort_idle");

        // Max limit with the limit lowered mid-run; pointer is at 0 now.
        req_r   = 4'b0001;
        limit_r = {8'd0, 8'd0, 8'd0, 8'hFF};
        tick();
        check_run("max_run", 4'b0001, 0);
        limit_r = {8'd0, 8'd0, 8'd0, 8'd2};
        for (int k = 1; k <= 255; k++) begin
            tick();
            check_run("max_run", 4'b0001, k);
        end
        tick();
        check_done("max_done", 0, 255);
        req_r = 4'b0000;
        tick();
        tick();
        check_idle("max_idle");

        // Reset at count 4; afterwards requester 1 wins over 3 from pointer 0.
        req_r   = 4'b0100;
        limit_r = {8'd5, 8'd9, 8'd5, 8'd0};
        for (int k = 0; k <= 4; k++) begin
            tick();
            check_run("rst_run", 4'b0100, k);
        end
        reset = 1'b1;
        req_r = 4'b1010;
        tick();
        check_idle("rst_clear");
        check_eq("rst_state", 32'(state_dbg), 32'h0);
        reset = 1'b0;
        tick();
        check_run("rst_regrant", 4'b0010, 0);
        req_r = 4'b0000;
        tick();
        check_idle("rst_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
